// File: rtl/nxn_board_game_engine_if.sv
// Move handshake bundle between the input front-end and the board engine.
// Master offers a cell index; slave accepts it while move_ready is high.
interface nxn_board_game_engine_if #(
    parameter int POSW = 4
);
    logic            move_valid;
    logic [POSW-1:0] move_pos;
    logic            move_ready;

    modport master (
        output move_valid,
        output move_pos,
        input  move_ready
    );

    modport slave (
        input  move_valid,
        input  move_pos,
        output move_ready
    );
endinterface

// File: rtl/nxn_board_game_engine.sv
// N x N board, K-in-a-row two-player engine with a sequential ray-scan win check.
// Optional MOVE_TIMER_EN: the player to move forfeits after TIMEOUT_CYCLES idle clocks.
module nxn_board_game_engine #(
    parameter int N = 3,
    parameter int K = 3,
    parameter int TIMEOUT_CYCLES = 1000,
    localparam int POSW = $clog2(N * N)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    nxn_board_game_engine_if.slave mv_if,
    output logic                   turn,
    output logic                   illegal,
    output logic                   result_valid,
    output logic                   win,
    output logic                   draw,
    output logic [1:0]             winner,
    output logic                   game_over,
    input  logic [POSW-1:0]        rd_pos,
    output logic [1:0]             rd_cell
);

    localparam int NN  = N * N;
    localparam int CW  = $clog2(N);
    localparam int MCW = $clog2(NN + 1);
    localparam int SW  = $clog2(K);
    localparam int RW  = $clog2(2 * K);

    if (N < 3 || N > 15 || K < 2 || K > N || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("nxn_board_game_engine: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE,
        WAIT_MOVE,
        CHECK,
        RESOLVE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       board_q [NN];
    logic [1:0]       board_d [NN];
    logic [MCW-1:0]   cnt_q, cnt_d;
    logic             turn_q, turn_d;
    logic             illegal_q, illegal_d;
    logic             rv_q, rv_d;
    logic             win_q, win_d;
    logic             draw_q, draw_d;
    logic [1:0]       winner_q, winner_d;
    logic [1:0]       rd_cell_q, rd_cell_d;
    logic [CW-1:0]    row0_q, row0_d;
    logic [CW-1:0]    col0_q, col0_d;
    logic [CW-1:0]    cur_r_q, cur_r_d;
    logic [CW-1:0]    cur_c_q, cur_c_d;
    logic [2:0]       dir_q, dir_d;
    logic [SW-1:0]    step_q, step_d;
    logic             stop_q, stop_d;
    logic [RW-1:0]    run_q, run_d;
    logic             found_q, found_d;
`ifdef MOVE_TIMER_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]    timer_q, timer_d;
`endif

    logic             hs;
    logic [1:0]       code;
    logic             in_range;
    logic [1:0]       tgt_cell;
    logic             legal;
    logic             r_inc, r_dec, c_inc, c_dec;
    logic             at_edge;
    logic [CW-1:0]    nr, nc;
    logic [POSW-1:0]  nidx;
    logic [1:0]       ncell;
    logic             hit;
    logic [RW-1:0]    run_n;

    assign hs       = mv_if.move_valid & mv_if.move_ready;
    assign code     = turn_q ? 2'b10 : 2'b01;
    assign in_range = 32'(mv_if.move_pos) < NN;
    assign tgt_cell = in_range ? board_q[mv_if.move_pos] : 2'b00;
    assign legal    = in_range && (tgt_cell == 2'b00);

    // Neighbour one step along the current ray, with edge detection so rows never wrap.
    always_comb begin
        r_inc = 1'b0;
        r_dec = 1'b0;
        c_inc = 1'b0;
        c_dec = 1'b0;
        unique case (dir_q)
            3'd0: c_inc = 1'b1;
            3'd1: c_dec = 1'b1;
            3'd2: r_inc = 1'b1;
            3'd3: r_dec = 1'b1;
            3'd4: begin r_inc = 1'b1; c_inc = 1'b1; end
            3'd5: begin r_dec = 1'b1; c_dec = 1'b1; end
            3'd6: begin r_dec = 1'b1; c_inc = 1'b1; end
            3'd7: begin r_inc = 1'b1; c_dec = 1'b1; end
            default: ;
        endcase
        at_edge = (r_inc && cur_r_q == CW'(N - 1)) ||
                  (r_dec && cur_r_q == '0) ||
                  (c_inc && cur_c_q == CW'(N - 1)) ||
                  (c_dec && cur_c_q == '0);
        nr = r_inc ? cur_r_q + CW'(1) : (r_dec ? cur_r_q - CW'(1) : cur_r_q);
        nc = c_inc ? cur_c_q + CW'(1) : (c_dec ? cur_c_q - CW'(1) : cur_c_q);
        nidx  = POSW'(32'(nr) * N + 32'(nc));
        ncell = at_edge ? 2'b00 : board_q[nidx];
        hit   = !stop_q && !at_edge && (ncell == code);
        run_n = run_q + RW'(hit);
    end

    // Game FSM next-state: move acceptance, ray scan, result resolution.
    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        cnt_d     = cnt_q;
        turn_d    = turn_q;
        illegal_d = 1'b0;
        rv_d      = 1'b0;
        win_d     = win_q;
        draw_d    = draw_q;
        winner_d  = winner_q;
        row0_d    = row0_q;
        col0_d    = col0_q;
        cur_r_d   = cur_r_q;
        cur_c_d   = cur_c_q;
        dir_d     = dir_q;
        step_d    = step_q;
        stop_d    = stop_q;
        run_d     = run_q;
        found_d   = found_q;
        rd_cell_d = (32'(rd_pos) < NN) ? board_q[rd_pos] : 2'b00;
`ifdef MOVE_TIMER_EN
        timer_d   = '0;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    for (int i = 0; i < NN; i++) board_d[i] = 2'b00;
                    cnt_d    = '0;
                    turn_d   = 1'b0;
                    win_d    = 1'b0;
                    draw_d   = 1'b0;
                    winner_d = 2'b00;
                    state_d  = WAIT_MOVE;
                end
            end
            WAIT_MOVE: begin
                if (hs) begin
                    if (legal) begin
                        board_d[mv_if.move_pos] = code;
                        cnt_d   = cnt_q + MCW'(1);
                        row0_d  = CW'(32'(mv_if.move_pos) / N);
                        col0_d  = CW'(32'(mv_if.move_pos) % N);
                        cur_r_d = CW'(32'(mv_if.move_pos) / N);
                        cur_c_d = CW'(32'(mv_if.move_pos) % N);
                        dir_d   = 3'd0;
                        step_d  = '0;
                        stop_d  = 1'b0;
                        run_d   = RW'(1);
                        found_d = 1'b0;
                        state_d = CHECK;
                    end else begin
                        illegal_d = 1'b1;
                    end
`ifdef MOVE_TIMER_EN
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    win_d    = 1'b1;
                    winner_d = turn_q ? 2'b01 : 2'b10;
                    rv_d     = 1'b1;
                    state_d  = DONE;
                end else begin
                    timer_d = timer_q + TW'(1);
`endif
                end
            end
            CHECK: begin
                if (hit) begin
                    cur_r_d = nr;
                    cur_c_d = nc;
                end else begin
                    stop_d = 1'b1;
                end
                run_d = run_n;
                if (step_q == SW'(K - 2)) begin
                    step_d  = '0;
                    stop_d  = 1'b0;
                    cur_r_d = row0_q;
                    cur_c_d = col0_q;
                    dir_d   = dir_q + 3'd1;
                    if (dir_q[0]) begin
                        if (32'(run_n) >= K) found_d = 1'b1;
                        run_d = RW'(1);
                    end
                    if (dir_q == 3'd7) state_d = RESOLVE;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            RESOLVE: begin
                rv_d = 1'b1;
                if (found_q) begin
                    win_d    = 1'b1;
                    winner_d = code;
                    state_d  = DONE;
                end else if (32'(cnt_q) == NN) begin
                    draw_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = WAIT_MOVE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and board registers; reset clears the board and drops any scan in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            for (int i = 0; i < NN; i++) board_q[i] <= 2'b00;
            cnt_q     <= '0;
            turn_q    <= 1'b0;
            illegal_q <= 1'b0;
            rv_q      <= 1'b0;
            win_q     <= 1'b0;
            draw_q    <= 1'b0;
            winner_q  <= 2'b00;
            rd_cell_q <= 2'b00;
            row0_q    <= '0;
            col0_q    <= '0;
            cur_r_q   <= '0;
            cur_c_q   <= '0;
            dir_q     <= 3'd0;
            step_q    <= '0;
            stop_q    <= 1'b0;
            run_q     <= '0;
            found_q   <= 1'b0;
`ifdef MOVE_TIMER_EN
            timer_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            board_q   <= board_d;
            cnt_q     <= cnt_d;
            turn_q    <= turn_d;
            illegal_q <= illegal_d;
            rv_q      <= rv_d;
            win_q     <= win_d;
            draw_q    <= draw_d;
            winner_q  <= winner_d;
            rd_cell_q <= rd_cell_d;
            row0_q    <= row0_d;
            col0_q    <= col0_d;
            cur_r_q   <= cur_r_d;
            cur_c_q   <= cur_c_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
            stop_q    <= stop_d;
            run_q     <= run_d;
            found_q   <= found_d;
`ifdef MOVE_TIMER_EN
            timer_q   <= timer_d;
`endif
        end
    end

    assign mv_if.move_ready = (state_q == WAIT_MOVE);
    assign turn             = turn_q;
    assign illegal          = illegal_q;
    assign result_valid     = rv_q;
    assign win              = win_q;
    assign draw             = draw_q;
    assign winner           = winner_q;
    assign game_over        = (state_q == DONE);
    assign rd_cell          = rd_cell_q;

endmodule

// File: tb/tb_nxn_board_game_engine.sv
// Bench for nxn_board_game_engine: a 3x3/K=3 and a 5x5/K=4 instance
// checked against a whole-board line-search reference model.
module tb_nxn_board_game_engine;

    localparam int T0 = 20;

    logic clock = 1'b0;
    logic reset;
    logic [1:0] start;
    logic [1:0] mv;
    logic [4:0] mp [2];
    logic [4:0] rp [2];

    always #5 clock = ~clock;

    nxn_board_game_engine_if #(.POSW(4)) bus0 ();
    nxn_board_game_engine_if #(.POSW(5)) bus1 ();

    assign bus0.move_valid = mv[0];
    assign bus0.move_pos   = mp[0][3:0];
    assign bus1.move_valid = mv[1];
    assign bus1.move_pos   = mp[1];

    wire [1:0] o_turn, o_ill, o_rv, o_win, o_draw, o_go;
    wire [1:0][1:0] o_winner;
    wire [1:0][1:0] o_rd;
    wire [1:0] o_ready;
    assign o_ready = {bus1.move_ready, bus0.move_ready};

    nxn_board_game_engine #(.N(3), .K(3), .TIMEOUT_CYCLES(T0)) u_dut0 (
        .clock(clock), .reset(reset), .start(start[0]), .mv_if(bus0),
        .turn(o_turn[0]), .illegal(o_ill[0]), .result_valid(o_rv[0]),
        .win(o_win[0]), .draw(o_draw[0]), .winner(o_winner[0]),
        .game_over(o_go[0]), .rd_pos(rp[0][3:0]), .rd_cell(o_rd[0])
    );

    nxn_board_game_engine #(.N(5), .K(4)) u_dut1 (
        .clock(clock), .reset(reset), .start(start[1]), .mv_if(bus1),
        .turn(o_turn[1]), .illegal(o_ill[1]), .result_valid(o_rv[1]),
        .win(o_win[1]), .draw(o_draw[1]), .winner(o_winner[1]),
        .game_over(o_go[1]), .rd_pos(rp[1]), .rd_cell(o_rd[1])
    );

    int mb [2][225];
    int mcnt [2];
    int mturn [2];
    int vec = 0;
    int bad = 0;

    function automatic int nn(input int s);
        return (s != 0) ? 5 : 3;
    endfunction

    function automatic int kk(input int s);
        return (s != 0) ? 4 : 3;
    endfunction

    // Any K-long straight line of this code anywhere on the board.
    function automatic bit has_line(input int s, input int code);
        int n, k, dr, dc, rr, cc;
        bit ok;
        n = nn(s);
        k = kk(s);
        for (int d = 0; d < 4; d++) begin
            dr = (d == 0) ? 0 : 1;
            dc = (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 1 : -1;
            for (int r = 0; r < n; r++) begin
                for (int c = 0; c < n; c++) begin
                    ok = 1'b1;
                    for (int i = 0; i < k; i++) begin
                        rr = r + dr * i;
                        cc = c + dc * i;
                        if (rr < 0 || rr >= n || cc < 0 || cc >= n) ok = 1'b0;
                        else if (mb[s][rr * n + cc] != code) ok = 1'b0;
                    end
                    if (ok) return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic model_clear(input int s);
        for (int i = 0; i < 225; i++) mb[s][i] = 0;
        mcnt[s]  = 0;
        mturn[s] = 0;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        model_clear(0);
        model_clear(1);
        tick;
    endtask

    task automatic check_board(input int s);
        int lim, exp;
        lim = (s != 0) ? 32 : 16;
        for (int p = 0; p < lim; p++) begin
            rp[s] = 5'(p);
            tick;
            exp = (p < nn(s) * nn(s)) ? mb[s][p] : 0;
            vec++;
            if (o_rd[s] !== 2'(exp)) begin
                bad++;
                $display("FAIL rd_cell s=%0d pos=%0d got %0d want %0d", s, p, o_rd[s], exp);
            end
        end
    endtask

    task automatic do_start(input int s);
        start[s] = 1'b1;
        tick;
        start[s] = 1'b0;
        model_clear(s);
        vec++;
        if ({o_ready[s], o_turn[s], o_win[s], o_draw[s], o_winner[s], o_go[s]} !== 7'b1000000) begin
            bad++;
            $display("FAIL start s=%0d got rdy=%b turn=%b win=%b draw=%b winner=%b go=%b want 1,0,0,0,00,0",
                     s, o_ready[s], o_turn[s], o_win[s], o_draw[s], o_winner[s], o_go[s]);
        end
    endtask

    task automatic play_move(input int s, input int pos, input bit poke, output bit done);
        int cyc, code, lat;
        bit legal, exp_w, exp_d;
        done = 1'b0;
        cyc = 0;
        while (!o_ready[s] && cyc < 100) begin
            tick;
            cyc++;
        end
        vec++;
        if (!o_ready[s]) begin
            bad++;
            $display("FAIL ready_wait s=%0d got 0 want 1", s);
            return;
        end
        legal = (pos < nn(s) * nn(s)) && (mb[s][pos] == 0);
        mv[s] = 1'b1;
        mp[s] = 5'(pos);
        tick;
        mv[s] = 1'b0;
        vec++;
        if (o_ill[s] !== !legal) begin
            bad++;
            $display("FAIL illegal s=%0d pos=%0d got %b want %b", s, pos, o_ill[s], !legal);
        end
        if (!legal) begin
            vec++;
            if (o_turn[s] !== 1'(mturn[s]) || o_rv[s] !== 1'b0) begin
                bad++;
                $display("FAIL illegal_turn s=%0d got turn=%b rv=%b want turn=%0d rv=0",
                         s, o_turn[s], o_rv[s], mturn[s]);
            end
            return;
        end
        code = mturn[s] + 1;
        mb[s][pos] = code;
        mcnt[s]++;
        exp_w = has_line(s, code);
        exp_d = !exp_w && (mcnt[s] == nn(s) * nn(s));
        lat = 8 * (kk(s) - 1) + 1;
        cyc = 0;
        while (cyc < 200) begin
            if (poke && cyc == 2) begin
                start[s] = 1'b1;
                mv[s] = 1'b1;
            end
            tick;
            cyc++;
            start[s] = 1'b0;
            mv[s] = 1'b0;
            if (o_rv[s]) break;
        end
        vec++;
        if (!o_rv[s] || cyc != lat) begin
            bad++;
            $display("FAIL latency s=%0d pos=%0d got %0d cycles (rv=%b) want %0d", s, pos, cyc, o_rv[s], lat);
        end
        if (!exp_w && !exp_d) mturn[s] = 1 - mturn[s];
        vec++;
        if ({o_win[s], o_draw[s], o_winner[s], o_go[s]} !== {exp_w, exp_d, 2'(exp_w ? code : 0), exp_w | exp_d}) begin
            bad++;
            $display("FAIL outcome s=%0d pos=%0d got win=%b draw=%b winner=%b go=%b want %b %b %0d %b",
                     s, pos, o_win[s], o_draw[s], o_winner[s], o_go[s], exp_w, exp_d,
                     exp_w ? code : 0, exp_w | exp_d);
        end
        vec++;
        if (o_turn[s] !== 1'(mturn[s])) begin
            bad++;
            $display("FAIL turn s=%0d got %b want %0d", s, o_turn[s], mturn[s]);
        end
        tick;
        vec++;
        if (o_rv[s] !== 1'b0) begin
            bad++;
            $display("FAIL rv_pulse s=%0d got %b want 0", s, o_rv[s]);
        end
        done = exp_w | exp_d;
    endtask

    task automatic test_reset;
        apply_reset;
        for (int s = 0; s < 2; s++) begin
            vec++;
            if ({o_ready[s], o_turn[s], o_ill[s], o_rv[s], o_win[s], o_draw[s], o_winner[s], o_go[s]} !== 9'b0) begin
                bad++;
                $display("FAIL reset_outputs s=%0d got rdy=%b turn=%b ill=%b rv=%b win=%b draw=%b winner=%b go=%b want all 0",
                         s, o_ready[s], o_turn[s], o_ill[s], o_rv[s], o_win[s], o_draw[s], o_winner[s], o_go[s]);
            end
            check_board(s);
        end
    endtask

    task automatic test_illegal;
        bit dn;
        do_start(0);
        play_move(0, 4, 1'b0, dn);
        play_move(0, 4, 1'b0, dn);
        play_move(0, 9, 1'b0, dn);
        vec++;
        if (o_turn[0] !== 1'b1) begin
            bad++;
            $display("FAIL illegal_keep_turn got %b want 1", o_turn[0]);
        end
        start[0] = 1'b1;
        tick;
        start[0] = 1'b0;
        check_board(0);
        apply_reset;
    endtask

    task automatic test_p1_win;
        int seq [7] = '{4, 0, 8, 1, 2, 6, 5};
        bit dn;
        do_start(0);
        foreach (seq[i]) play_move(0, seq[i], 1'b0, dn);
        vec++;
        if (!dn || o_win[0] !== 1'b1 || o_winner[0] !== 2'b01) begin
            bad++;
            $display("FAIL p1_win got win=%b winner=%b want 1 01", o_win[0], o_winner[0]);
        end
    endtask

    task automatic test_draw;
        int seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        bit dn;
        do_start(0);
        foreach (seq[i]) play_move(0, seq[i], 1'b0, dn);
        vec++;
        if ({o_draw[0], o_win[0], o_go[0]} !== 3'b101) begin
            bad++;
            $display("FAIL draw got draw=%b win=%b go=%b want 1 0 1", o_draw[0], o_win[0], o_go[0]);
        end
        check_board(0);
    endtask

    task automatic test_wrap_and_diag;
        int seq [13] = '{3, 20, 4, 21, 5, 22, 6, 0, 12, 1, 18, 9, 24};
        bit dn;
        do_start(1);
        foreach (seq[i]) begin
            play_move(1, seq[i], (i == 1), dn);
            if (i == 6) begin
                vec++;
                if (o_win[1] !== 1'b0) begin
                    bad++;
                    $display("FAIL row_wrap got win=%b want 0", o_win[1]);
                end
            end
        end
        vec++;
        if (o_win[1] !== 1'b1 || o_winner[1] !== 2'b01) begin
            bad++;
            $display("FAIL diag_win got win=%b winner=%b want 1 01", o_win[1], o_winner[1]);
        end
        check_board(1);
    endtask

    task automatic test_random;
        int s, pos, empt, pick, guard;
        bit dn;
        for (int g = 0; g < 6; g++) begin
            s = g % 2;
            do_start(s);
            dn = 1'b0;
            guard = 0;
            while (!dn && guard < 80) begin
                guard++;
                if ($urandom_range(0, 3) != 0) begin
                    empt = 0;
                    for (int i = 0; i < nn(s) * nn(s); i++) if (mb[s][i] == 0) empt++;
                    pick = $urandom_range(0, empt - 1);
                    pos = 0;
                    for (int i = 0; i < nn(s) * nn(s); i++) begin
                        if (mb[s][i] == 0) begin
                            if (pick == 0) pos = i;
                            pick--;
                        end
                    end
                end else begin
                    pos = $urandom_range(0, (s != 0) ? 31 : 15);
                end
                play_move(s, pos, 1'b0, dn);
            end
            check_board(s);
        end
    endtask

    task automatic test_reset_mid_check;
        int cnt;
        do_start(0);
        mv[0] = 1'b1;
        mp[0] = 5'd4;
        tick;
        mv[0] = 1'b0;
        repeat (5) tick;
        #2;
        reset = 1'b1;
        #1;
        vec++;
        if ({o_ready[0], o_go[0], o_rv[0]} !== 3'b000) begin
            bad++;
            $display("FAIL mid_reset got rdy=%b go=%b rv=%b want 0 0 0", o_ready[0], o_go[0], o_rv[0]);
        end
        tick;
        reset = 1'b0;
        model_clear(0);
        model_clear(1);
        cnt = 0;
        repeat (30) begin
            tick;
            if (o_rv[0]) cnt++;
        end
        vec++;
        if (cnt != 0) begin
            bad++;
            $display("FAIL mid_reset_rv got %0d pulses want 0", cnt);
        end
        check_board(0);
    endtask

`ifdef MOVE_TIMER_EN
    task automatic test_timeout;
        int cyc;
        do_start(0);
        cyc = 0;
        while (cyc < 100) begin
            tick;
            cyc++;
            if (o_rv[0]) break;
        end
        vec++;
        if (!o_rv[0] || cyc != T0) begin
            bad++;
            $display("FAIL timeout_latency got %0d (rv=%b) want %0d", cyc, o_rv[0], T0);
        end
        vec++;
        if ({o_win[0], o_winner[0], o_go[0]} !== 4'b1101) begin
            bad++;
            $display("FAIL timeout_result got win=%b winner=%b go=%b want 1 10 1",
                     o_win[0], o_winner[0], o_go[0]);
        end
    endtask
`else
    task automatic test_no_timeout;
        int cnt;
        do_start(0);
        cnt = 0;
        repeat (50) begin
            tick;
            if (o_rv[0] || o_go[0]) cnt++;
        end
        vec++;
        if (cnt != 0 || o_ready[0] !== 1'b1) begin
            bad++;
            $display("FAIL no_timeout got events=%0d rdy=%b want 0 1", cnt, o_ready[0]);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 2'b00;
        mv    = 2'b00;
        mp[0] = '0;
        mp[1] = '0;
        rp[0] = '0;
        rp[1] = '0;
        test_reset;
        test_illegal;
        test_p1_win;
        test_draw;
        test_wrap_and_diag;
        test_random;
        test_reset_mid_check;
`ifdef MOVE_TIMER_EN
        test_timeout;
`else
        test_no_timeout;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
